// File: rtl/sdram_slot_arbiter.sv
// Picks one of four requesters (video, CPU, DMA, blitter) per 8 MHz SDRAM slot and forces refresh gaps.
// Build option: define SDRAM_ARB_VIDEO_PRIO_EN to give port 0 (video) fixed priority over ports 1..3.
module sdram_slot_arbiter #(
  parameter int REFRESH_MAX = 48
) (
  input  logic        clk_8,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [3:0]  p_we,
  input  logic [95:0] p_addr,
  input  logic [7:0]  p_ds,
  input  logic [63:0] p_din,
  output logic [3:0]  ack,
  output logic [63:0] rdata,
  output logic [3:0]  grant,
  output logic        sd_oe,
  output logic        sd_we,
  output logic [23:0] sd_addr,
  output logic [1:0]  sd_ds,
  output logic [15:0] sd_din,
  input  logic [63:0] sd_dout
);
  // Handshake: a requester raises req[n] with p_* stable and holds it until ack[n]; grant[n] marks
  // the slot its access occupies on the sd_* bus, and ack[n] pulses for one cycle in the next slot.
  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} slot_state_t;

  slot_state_t state_q, state_d;
  logic [3:0]  grant_d, eligible;
  logic [1:0]  rr_last, rr_last_d, win_idx;
  logic        win_valid;
  logic [5:0]  busy_cnt, busy_cnt_d;
  logic        sel_we;
  logic [23:0] sel_addr;
  logic [1:0]  sel_ds;
  logic [15:0] sel_din;
`ifdef SDRAM_ARB_VIDEO_PRIO_EN
  logic [2:0]  cand;
`else
  logic [1:0]  cand;
`endif

  // The port owning the slot that is ending may not take the next one.
  always_comb begin
    eligible  = req & ((state_q == S_ACCESS) ? ~grant : 4'b1111);
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = '0;
`ifdef SDRAM_ARB_VIDEO_PRIO_EN
    if (eligible[0]) begin
      win_valid = 1'b1;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        cand = {1'b0, rr_last} + 3'(k);
        if (cand > 3'd3) cand = cand - 3'd3;
        if (!win_valid && eligible[cand[1:0]]) begin
          win_valid = 1'b1;
          win_idx   = cand[1:0];
        end
      end
    end
`else
    for (int k = 1; k <= 4; k++) begin
      cand = rr_last + 2'(k);
      if (!win_valid && eligible[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
`endif
  end

  always_comb begin
    state_d    = S_IDLE;
    grant_d    = 4'b0000;
    rr_last_d  = rr_last;
    busy_cnt_d = 6'd0;
    if (int'(busy_cnt) != REFRESH_MAX && win_valid) begin
      state_d    = S_ACCESS;
      grant_d    = 4'b0001 << win_idx;
      busy_cnt_d = busy_cnt + 6'd1;
`ifdef SDRAM_ARB_VIDEO_PRIO_EN
      if (win_idx != 2'd0) rr_last_d = win_idx;
`else
      rr_last_d = win_idx;
`endif
    end
  end

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_ds   = '0;
    sel_din  = '0;
    for (int i = 0; i < 4; i++) begin
      if (win_idx == 2'(i)) begin
        sel_we   = p_we[i];
        sel_addr = p_addr[i*24 +: 24];
        sel_ds   = p_ds[i*2 +: 2];
        sel_din  = p_din[i*16 +: 16];
      end
    end
  end

  always_ff @(posedge clk_8 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      grant    <= '0;
      rr_last  <= 2'd3;
      busy_cnt <= '0;
      ack      <= '0;
      rdata    <= '0;
      sd_oe    <= 1'b0;
      sd_we    <= 1'b0;
      sd_addr  <= '0;
      sd_ds    <= '0;
      sd_din   <= '0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      rr_last  <= rr_last_d;
      busy_cnt <= busy_cnt_d;
      ack      <= (state_q == S_ACCESS) ? grant : 4'b0000;
      if (state_q == S_ACCESS && sd_oe) rdata <= sd_dout;
      // Address and write data hold through idle slots; only the strobes and commands drop.
      if (state_d == S_ACCESS) begin
        sd_oe   <= ~sel_we;
        sd_we   <= sel_we;
        sd_addr <= sel_addr;
        sd_ds   <= sel_ds;
        sd_din  <= sel_din;
      end else begin
        sd_oe <= 1'b0;
        sd_we <= 1'b0;
        sd_ds <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: directed vector table, hand sequences, and random traffic vs a slot model.
module tb_sdram_slot_arbiter;
  localparam int RMAX = 4;
  localparam int SW   = 116;
  localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DB = 64'h5555_6666_7777_8888;
  localparam logic [63:0] DC = 64'h9999_AAAA_BBBB_CCCC;

  typedef struct packed {
    logic [3:0]  ack;
    logic [63:0] rdata;
    logic [3:0]  grant;
    logic        oe;
    logic        we;
    logic [23:0] addr;
    logic [1:0]  ds;
    logic [15:0] din;
  } snap_t;

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [63:0] dout;
    logic [3:0]  exp_grant;
    logic [3:0]  exp_ack;
    logic        exp_oe;
    logic        exp_we;
    logic [63:0] exp_rdata;
  } vec_t;

  // clock / reset
  logic        clk_8   = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req     = '0;
  logic [3:0]  p_we    = '0;
  logic [95:0] p_addr  = '0;
  logic [7:0]  p_ds    = '0;
  logic [63:0] p_din   = '0;
  logic [63:0] sd_dout = '0;
  logic [3:0]  ack, grant;
  logic [63:0] rdata;
  logic        sd_oe, sd_we;
  logic [23:0] sd_addr;
  logic [1:0]  sd_ds;
  logic [15:0] sd_din;

  sdram_slot_arbiter #(.REFRESH_MAX(RMAX)) dut (
    .clk_8(clk_8), .reset_n(reset_n), .req(req), .p_we(p_we), .p_addr(p_addr),
    .p_ds(p_ds), .p_din(p_din), .ack(ack), .rdata(rdata), .grant(grant),
    .sd_oe(sd_oe), .sd_we(sd_we), .sd_addr(sd_addr), .sd_ds(sd_ds),
    .sd_din(sd_din), .sd_dout(sd_dout)
  );

  always #5 clk_8 = ~clk_8;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one record per slot, ports searched in cyclic order after the last RR winner
  logic [SW-1:0] exp_q[$];
  int    m_prev    = -1;
  bit    m_prev_rd = 1'b0;
  int    m_rr      = 3;
  int    m_busy    = 0;
  int    m_win, m_p;
  snap_t m_out     = '0;
  snap_t e_snap;

  always @(negedge reset_n) begin
    exp_q.delete();
    m_prev = -1; m_prev_rd = 1'b0; m_rr = 3; m_busy = 0; m_out = '0;
  end

  always @(posedge clk_8) begin
    if (!reset_n) begin
      exp_q.push_back('0);
    end else begin
      m_out.ack = (m_prev >= 0) ? 4'(1 << m_prev) : 4'b0000;
      if (m_prev >= 0 && m_prev_rd) m_out.rdata = sd_dout;
      m_win = -1;
      if (m_busy == RMAX) begin
        m_busy = 0;
      end else begin
`ifdef SDRAM_ARB_VIDEO_PRIO_EN
        if (req[0] && m_prev != 0) m_win = 0;
        else for (int k = 1; k <= 3; k++) begin
          m_p = (m_rr - 1 + k) % 3 + 1;
          if (m_win < 0 && req[m_p] && m_p != m_prev) m_win = m_p;
        end
`else
        for (int k = 1; k <= 4; k++) begin
          m_p = (m_rr + k) % 4;
          if (m_win < 0 && req[m_p] && m_p != m_prev) m_win = m_p;
        end
`endif
        if (m_win >= 0) begin
          m_busy++;
`ifdef SDRAM_ARB_VIDEO_PRIO_EN
          if (m_win != 0) m_rr = m_win;
`else
          m_rr = m_win;
`endif
        end else begin
          m_busy = 0;
        end
      end
      if (m_win >= 0) begin
        m_out.grant = 4'(1 << m_win);
        m_out.oe    = !p_we[m_win];
        m_out.we    = p_we[m_win];
        m_out.addr  = p_addr[m_win*24 +: 24];
        m_out.ds    = p_ds[m_win*2 +: 2];
        m_out.din   = p_din[m_win*16 +: 16];
      end else begin
        m_out.grant = '0;
        m_out.oe    = 1'b0;
        m_out.we    = 1'b0;
        m_out.ds    = '0;
      end
      m_prev    = m_win;
      m_prev_rd = (m_win >= 0) && !p_we[m_win];
      exp_q.push_back(m_out);
    end
  end

  // scoreboard: compare every slot against the model
  always @(negedge clk_8) begin
    if (exp_q.size() > 0) begin
      e_snap = exp_q.pop_front();
      chk("sb_ack",     64'(ack),     64'(e_snap.ack));
      chk("sb_rdata",   rdata,        e_snap.rdata);
      chk("sb_grant",   64'(grant),   64'(e_snap.grant));
      chk("sb_sd_oe",   64'(sd_oe),   64'(e_snap.oe));
      chk("sb_sd_we",   64'(sd_we),   64'(e_snap.we));
      chk("sb_sd_addr", 64'(sd_addr), 64'(e_snap.addr));
      chk("sb_sd_ds",   64'(sd_ds),   64'(e_snap.ds));
      chk("sb_sd_din",  64'(sd_din),  64'(e_snap.din));
    end
  end

  // driver tasks
  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w, input logic [63:0] d,
                              input logic [3:0] g, input logic [3:0] a, input logic oe,
                              input logic we, input logic [63:0] rd);
    vec_t v;
    v = '{req: r, we: w, dout: d, exp_grant: g, exp_ack: a, exp_oe: oe, exp_we: we, exp_rdata: rd};
    return v;
  endfunction

  task automatic raise(input int p);
    req[p]             = 1'b1;
    p_we[p]            = 1'($urandom_range(0, 1));
    p_addr[p*24 +: 24] = 24'($urandom);
    p_ds[p*2 +: 2]     = 2'($urandom_range(0, 3));
    p_din[p*16 +: 16]  = 16'($urandom);
  endtask

  vec_t       tv[$];
  logic [3:0] prev_g;
  logic [3:0] order_exp[4];

  initial begin
    // single read, write passthrough, RR fairness with a forced refresh, then all four requesting
    tv.push_back(mk(4'b0010, 4'b0000, DA, 4'b0010, 4'b0000, 1'b1, 1'b0, 64'h0));
    tv.push_back(mk(4'b0010, 4'b0000, DA, 4'b0000, 4'b0010, 1'b0, 1'b0, DA));
    tv.push_back(mk(4'b0000, 4'b0000, DB, 4'b0000, 4'b0000, 1'b0, 1'b0, DA));
    tv.push_back(mk(4'b0100, 4'b0100, DB, 4'b0100, 4'b0000, 1'b0, 1'b1, DA));
    tv.push_back(mk(4'b0100, 4'b0100, DB, 4'b0000, 4'b0100, 1'b0, 1'b0, DA));
    tv.push_back(mk(4'b0000, 4'b0000, DB, 4'b0000, 4'b0000, 1'b0, 1'b0, DA));
    tv.push_back(mk(4'b1110, 4'b0000, DC, 4'b1000, 4'b0000, 1'b1, 1'b0, DA));
    tv.push_back(mk(4'b1110, 4'b0000, DC, 4'b0010, 4'b1000, 1'b1, 1'b0, DC));
    tv.push_back(mk(4'b1110, 4'b0000, DC, 4'b0100, 4'b0010, 1'b1, 1'b0, DC));
    tv.push_back(mk(4'b1110, 4'b0000, DC, 4'b1000, 4'b0100, 1'b1, 1'b0, DC));
    tv.push_back(mk(4'b1110, 4'b0000, DC, 4'b0000, 4'b1000, 1'b0, 1'b0, DC));
    tv.push_back(mk(4'b1110, 4'b0000, DC, 4'b0010, 4'b0000, 1'b1, 1'b0, DC));
    tv.push_back(mk(4'b0000, 4'b0000, DC, 4'b0000, 4'b0010, 1'b0, 1'b0, DC));
    tv.push_back(mk(4'b0000, 4'b0000, DC, 4'b0000, 4'b0000, 1'b0, 1'b0, DC));
`ifdef SDRAM_ARB_VIDEO_PRIO_EN
    tv.push_back(mk(4'b1111, 4'b0000, DC, 4'b0001, 4'b0000, 1'b1, 1'b0, DC));
    tv.push_back(mk(4'b1111, 4'b0000, DC, 4'b0100, 4'b0001, 1'b1, 1'b0, DC));
    tv.push_back(mk(4'b1111, 4'b0000, DC, 4'b0001, 4'b0100, 1'b1, 1'b0, DC));
    tv.push_back(mk(4'b1111, 4'b0000, DC, 4'b1000, 4'b0001, 1'b1, 1'b0, DC));
    tv.push_back(mk(4'b1111, 4'b0000, DC, 4'b0000, 4'b1000, 1'b0, 1'b0, DC));
    order_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0100};
`else
    tv.push_back(mk(4'b1111, 4'b0000, DC, 4'b0100, 4'b0000, 1'b1, 1'b0, DC));
    tv.push_back(mk(4'b1111, 4'b0000, DC, 4'b1000, 4'b0100, 1'b1, 1'b0, DC));
    tv.push_back(mk(4'b1111, 4'b0000, DC, 4'b0001, 4'b1000, 1'b1, 1'b0, DC));
    tv.push_back(mk(4'b1111, 4'b0000, DC, 4'b0010, 4'b0001, 1'b1, 1'b0, DC));
    tv.push_back(mk(4'b1111, 4'b0000, DC, 4'b0000, 4'b0010, 1'b0, 1'b0, DC));
    order_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
    tv.push_back(mk(4'b0000, 4'b0000, DC, 4'b0000, 4'b0000, 1'b0, 1'b0, DC));

    repeat (3) @(negedge clk_8);
    chk("reset_grant", 64'(grant), 64'h0);
    chk("reset_ack",   64'(ack),   64'h0);
    chk("reset_rdata", rdata,      64'h0);
    reset_n = 1'b1;

    p_addr[24 +: 24] = 24'h012345;
    p_addr[48 +: 24] = 24'h0ABCDE;
    p_din[32 +: 16]  = 16'hBEEF;
    p_ds[5:4]        = 2'b01;
    for (int i = 0; i < tv.size(); i++) begin
      req = tv[i].req; p_we = tv[i].we; sd_dout = tv[i].dout;
      @(negedge clk_8);
      chk("tv_grant", 64'(grant), 64'(tv[i].exp_grant));
      chk("tv_ack",   64'(ack),   64'(tv[i].exp_ack));
      chk("tv_sd_oe", 64'(sd_oe), 64'(tv[i].exp_oe));
      chk("tv_sd_we", 64'(sd_we), 64'(tv[i].exp_we));
      chk("tv_rdata", rdata,      tv[i].exp_rdata);
      if (i == 0) chk("tv_read_addr", 64'(sd_addr), 64'h012345);
      if (i == 3) begin
        chk("tv_write_din", 64'(sd_din), 64'hBEEF);
        chk("tv_write_ds",  64'(sd_ds),  64'h1);
      end
    end

    // refresh forcing: RMAX access slots then exactly one idle slot, repeating
    req = 4'b0110; p_we = 4'b0000; prev_g = 4'b0000;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk_8);
      chk("rf_busy", 64'(|grant), 64'((k % 5) != 4));
      chk("rf_no_repeat", 64'(grant & prev_g), 64'h0);
      if (grant == 4'b0000) chk("rf_idle_cmd", 64'({sd_oe, sd_we}), 64'h0);
      prev_g = grant;
    end
    req = 4'b0000;
    repeat (2) @(negedge clk_8);

    // reset in the middle of a granted read
    req = 4'b0010; p_we = 4'b0000;
    @(posedge clk_8);
    #2;
    chk("mid_grant", 64'(grant), 64'h2);
    chk("mid_sd_oe", 64'(sd_oe), 64'h1);
    reset_n = 1'b0;
    req = 4'b0000;
    #1;
    chk("mid_rst_grant", 64'(grant),   64'h0);
    chk("mid_rst_ack",   64'(ack),     64'h0);
    chk("mid_rst_oe",    64'(sd_oe),   64'h0);
    chk("mid_rst_addr",  64'(sd_addr), 64'h0);
    chk("mid_rst_din",   64'(sd_din),  64'h0);
    chk("mid_rst_rdata", rdata,        64'h0);
    repeat (2) @(negedge clk_8);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_8);
      chk("post_rst_no_ack", 64'(ack), 64'h0);
    end

    // grant order from a fresh reset with everyone requesting
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_8);
      chk("order_grant", 64'(grant), 64'(order_exp[k]));
    end
    req = 4'b0000;
    repeat (2) @(negedge clk_8);

    // random traffic following the requester rules
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 4; p++) begin
        if (req[p] && ack[p]) begin
          if ($urandom_range(0, 1) == 1) raise(p);
          else req[p] = 1'b0;
        end else if (req[p]) begin
          if ($urandom_range(0, 31) == 0) req[p] = 1'b0;
        end else if (!grant[p] && $urandom_range(0, 2) == 0) begin
          raise(p);
        end
      end
      sd_dout = {$urandom, $urandom};
      @(negedge clk_8);
    end
    req = 4'b0000;
    repeat (3) @(negedge clk_8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
